mdio_slave: RTL and testbench

- Clause-22 MDIO target (PHY-side responder) that pairs with the mdio_if master.
- Oversamples MDC/MDIO on the system clock, decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA, and presents a simple register-bank port.
- Turns the bus around and shifts out read data; used in PHY models and in FPGA-resident management registers.

---
 rtl/mdio_slave_pkg.sv | 21 ++
 rtl/mdio_sync_edge.sv | 34 +++
 rtl/mdio_slave.sv | 170 +++++++++++++++++
 tb/tb_mdio_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_slave_pkg.sv
// Shared MDIO definitions: frame codes, field widths and responder FSM states.
package mdio_slave_pkg;
  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;

  localparam int PHYAD_W     = 5;
  localparam int REGAD_W     = 5;
  localparam int DATA_W      = 16;
  localparam int PRE_LEN_DEF = 32;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHY,
    S_REG,
    S_TA,
    S_DATA
  } state_t;
endpackage

// File: rtl/mdio_sync_edge.sv
// Synchronizes mdc and mdi through identical flop chains and flags mdc edges.
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdi,
  output logic rise,
  output logic fall,
  output logic mdi_s
);
  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdi_q;
  logic                   mdc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_q <= '0;
      mdi_q <= '0;
      mdc_d <= 1'b0;
    end else begin
      mdc_q <= {mdc_q[SYNC_STAGES-2:0], mdc};
      mdi_q <= {mdi_q[SYNC_STAGES-2:0], mdi};
      mdc_d <= mdc_q[SYNC_STAGES-1];
    end
  end

  // mdi_s is taken from the same stage as the edge, so a rise sees the bit
  // that was on the wire when mdc went high.
  assign rise  = mdc_q[SYNC_STAGES-1] & ~mdc_d;
  assign fall  = ~mdc_q[SYNC_STAGES-1] & mdc_d;
  assign mdi_s = mdi_q[SYNC_STAGES-1];
endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: parses frames on synced mdc rises, drives read data on falls.
module mdio_slave
  import mdio_slave_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR    = 5'd17,
  parameter int                 PRE_LEN     = PRE_LEN_DEF,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mdc,
  input  logic               mdi,
  output logic               mdo,
  output logic               mdt,
  output logic [REGAD_W-1:0] reg_addr,
  output logic               reg_rd_req,
  input  logic [DATA_W-1:0]  reg_rd_data,
  output logic               reg_wr,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic               frame_err
);
  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  logic               rise, fall, mdi_s;
  state_t             state;
  logic [5:0]         pre_cnt;
  logic [3:0]         bit_cnt;
  logic               is_rd, match, first_bit, rd_cap;
  logic [PHYAD_W-1:0] addr_sh;
  logic [DATA_W-1:0]  shreg;
  logic               drive_rd;

  mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .mdc   (mdc),
    .mdi   (mdi),
    .rise  (rise),
    .fall  (fall),
    .mdi_s (mdi_s)
  );

  assign drive_rd = is_rd & match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_PRE;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      is_rd       <= 1'b0;
      match       <= 1'b0;
      first_bit   <= 1'b0;
      rd_cap      <= 1'b0;
      addr_sh     <= '0;
      shreg       <= '0;
      mdo         <= 1'b0;
      mdt         <= 1'b0;
      reg_addr    <= '0;
      reg_rd_req  <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
    end else begin
      reg_rd_req <= 1'b0;
      reg_wr     <= 1'b0;
      frame_err  <= 1'b0;
      // Register bank answers one clk after the request.
      rd_cap     <= reg_rd_req;
      if (rd_cap) shreg <= reg_rd_data;

      if (rise) begin
        case (state)
          S_PRE: begin
            if (mdi_s) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              if (pre_cnt == PRE_MAX) state <= S_ST;
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            bit_cnt <= '0;
            if (mdi_s == ST_CODE[0]) state <= S_OP;
            else begin
              frame_err <= 1'b1;
              state     <= S_PRE;
            end
          end
          S_OP: begin
            if (bit_cnt == 4'd0) begin
              first_bit <= mdi_s;
              bit_cnt   <= 4'd1;
            end else begin
              bit_cnt <= '0;
              if ({first_bit, mdi_s} == OP_RD) begin
                is_rd <= 1'b1;
                state <= S_PHY;
              end else if ({first_bit, mdi_s} == OP_WR) begin
                is_rd <= 1'b0;
                state <= S_PHY;
              end else begin
                frame_err <= 1'b1;
                state     <= S_PRE;
              end
            end
          end
          S_PHY: begin
            addr_sh <= {addr_sh[PHYAD_W-2:0], mdi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd4) begin
              match   <= ({addr_sh[PHYAD_W-2:0], mdi_s} == PHY_ADDR);
              bit_cnt <= '0;
              state   <= S_REG;
            end
          end
          S_REG: begin
            addr_sh <= {addr_sh[PHYAD_W-2:0], mdi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd4) begin
              reg_addr   <= {addr_sh[REGAD_W-2:0], mdi_s};
              reg_rd_req <= drive_rd;
              bit_cnt    <= '0;
              state      <= S_TA;
            end
          end
          S_TA: begin
            if (bit_cnt == 4'd0) begin
              first_bit <= mdi_s;
              bit_cnt   <= 4'd1;
            end else begin
              bit_cnt <= '0;
              // Only a matched write owns the TA check; reads have the bus turned.
              if (!is_rd && match && ({first_bit, mdi_s} != 2'b10)) begin
                frame_err <= 1'b1;
                state     <= S_PRE;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (!is_rd) shreg <= {shreg[DATA_W-2:0], mdi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state <= S_PRE;
              if (!is_rd && match) begin
                reg_wr      <= 1'b1;
                reg_wr_data <= {shreg[DATA_W-2:0], mdi_s};
              end
            end
          end
          default: state <= S_PRE;
        endcase
      end

      // Bus is released on every fall unless we own TA bit 2 or a read data bit.
      if (fall) begin
        mdt <= 1'b0;
        mdo <= 1'b0;
        if (drive_rd && state == S_TA && bit_cnt == 4'd1) begin
          mdt <= 1'b1;
        end else if (drive_rd && state == S_DATA) begin
          mdt   <= 1'b1;
          mdo   <= shreg[DATA_W-1];
          shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: behavioural MDIO master on a pulled-up net plus a frame-level model.
module tb_mdio_slave;
  localparam int HALF = 50;
  localparam int K_NONE = 0, K_ERR = 1, K_RD = 2, K_WR = 3, K_SILENT = 4;

  logic        clk = 1'b0;
  logic        rst, mdc, m_o, m_oe;
  logic        bus;
  logic        mdo, mdt;
  logic [4:0]  reg_addr;
  logic        reg_rd_req, reg_wr, frame_err;
  logic [15:0] reg_rd_data, reg_wr_data;
  logic [15:0] rd_val;
  logic        rd_valid = 1'b0;

  int compared = 0, mismatched = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_mdt = 0;
  int s_wr, s_rd, s_err, s_mdt;
  logic [4:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic        mdt_log [0:127];
  logic        bus_log [0:127];
  int          nbits;

  mdio_slave dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdi(bus), .mdo(mdo), .mdt(mdt),
    .reg_addr(reg_addr), .reg_rd_req(reg_rd_req), .reg_rd_data(reg_rd_data),
    .reg_wr(reg_wr), .reg_wr_data(reg_wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulled-up open net: master wins when driving, else the target, else 1.
  assign bus = m_oe ? m_o : (mdt ? mdo : 1'b1);

  // Register bank with one clk of read latency.
  always @(posedge clk) rd_valid <= reg_rd_req;
  assign reg_rd_data = rd_valid ? rd_val : 16'h0000;

  always @(negedge clk) begin
    if (reg_wr) begin
      n_wr++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wr_data;
    end
    if (reg_rd_req) begin
      n_rd++;
      last_rd_addr = reg_addr;
    end
    if (frame_err) n_err++;
    if (mdt) n_mdt++;
  end

  initial begin
    #(10_000_000);
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic int model_kind(int pre_n, logic [1:0] st, logic [1:0] op,
                                    logic [4:0] phy, logic [1:0] ta);
    if (pre_n < 32) return K_NONE;
    if (st != 2'b01) return K_ERR;
    if (op != 2'b10 && op != 2'b01) return K_ERR;
    if (phy != 5'd17) return K_SILENT;
    if (op == 2'b01 && ta != 2'b10) return K_ERR;
    return (op == 2'b10) ? K_RD : K_WR;
  endfunction

  function automatic logic [15:0] rdata_of(int pre_n);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[15-k] = bus_log[pre_n+17+k];
    return r;
  endfunction

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_err = n_err; s_mdt = n_mdt;
  endtask

  task automatic clock_bit(input logic v, input logic oe);
    m_o = v;
    m_oe = oe;
    #(HALF);
    mdt_log[nbits] = mdt;
    bus_log[nbits] = bus;
    nbits++;
    mdc = 1'b1;
    #(HALF);
    mdc = 1'b0;
  endtask

  // Leading driven 0 clears any partial preamble left over from the previous frame.
  task automatic run_frame(input int pre_n, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [1:0] ta, input logic [15:0] wd, input int abort_at);
    logic rd;
    rd = (op == 2'b10);
    nbits = 0;
    clock_bit(1'b0, 1'b1);
    repeat (pre_n) clock_bit(1'b1, 1'b1);
    for (int i = 1; i >= 0; i--) clock_bit(st[i], 1'b1);
    for (int i = 1; i >= 0; i--) clock_bit(op[i], 1'b1);
    for (int i = 4; i >= 0; i--) clock_bit(phy[i], 1'b1);
    for (int i = 4; i >= 0; i--) clock_bit(rg[i], 1'b1);
    for (int i = 1; i >= 0; i--) clock_bit(ta[i], !rd);
    for (int i = 15; i >= 0; i--) begin
      if (i == abort_at) begin
        m_o = wd[i];
        m_oe = !rd;
        #40;
        compared++;
        if (mdt !== 1'b1) begin
          mismatched++;
          $display("FAIL abort_pre_mdt: got %b want 1", mdt);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({mdt, mdo} !== 2'b00) begin
          mismatched++;
          $display("FAIL abort_async_release: mdt/mdo got %b want 00", {mdt, mdo});
        end
        #49;
        rst = 1'b0;
        m_oe = 1'b0;
        #100;
        return;
      end
      clock_bit(wd[i], !rd);
    end
    clock_bit(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mdc = 1'b0; m_o = 1'b1; m_oe = 1'b0; rd_val = '0;
    #100;
    compared++;
    if ({mdt, mdo, reg_rd_req, reg_wr, frame_err} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 00000", {mdt, mdo, reg_rd_req, reg_wr, frame_err});
    end
    compared++;
    if (reg_addr !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_addr: got %h want 00", reg_addr);
    end
    compared++;
    if (reg_wr_data !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_wdata: got %h want 0000", reg_wr_data);
    end
    rst = 1'b0;
    #100;
  endtask

  task automatic test_write();
    snap();
    run_frame(32, 2'b01, 2'b01, 5'b10001, 5'b10001, 2'b10, 16'h1111, -1);
    compared++;
    if (n_wr - s_wr !== 1 || n_rd - s_rd !== 0 || n_err - s_err !== 0) begin
      mismatched++;
      $display("FAIL write_pulses: wr/rd/err got %0d/%0d/%0d want 1/0/0",
               n_wr - s_wr, n_rd - s_rd, n_err - s_err);
    end
    compared++;
    if (last_wr_addr !== 5'd17 || last_wr_data !== 16'h1111) begin
      mismatched++;
      $display("FAIL write_payload: got %0d/%h want 17/1111", last_wr_addr, last_wr_data);
    end
    compared++;
    if (n_mdt - s_mdt !== 0) begin
      mismatched++;
      $display("FAIL write_mdt: got %0d drive cycles want 0", n_mdt - s_mdt);
    end
  endtask

  task automatic test_read();
    rd_val = 16'hA5C3;
    snap();
    run_frame(32, 2'b01, 2'b10, 5'b10001, 5'b10001, 2'b11, 16'h0, -1);
    compared++;
    if (n_rd - s_rd !== 1 || last_rd_addr !== 5'd17 || n_wr - s_wr !== 0 || n_err - s_err !== 0) begin
      mismatched++;
      $display("FAIL read_req: rd/addr/wr/err got %0d/%0d/%0d/%0d want 1/17/0/0",
               n_rd - s_rd, last_rd_addr, n_wr - s_wr, n_err - s_err);
    end
    compared++;
    if (mdt_log[47] !== 1'b0) begin
      mismatched++;
      $display("FAIL read_ta1: mdt got %b want 0", mdt_log[47]);
    end
    compared++;
    if ({mdt_log[48], bus_log[48]} !== 2'b10) begin
      mismatched++;
      $display("FAIL read_ta2: mdt/line got %b%b want 10", mdt_log[48], bus_log[48]);
    end
    compared++;
    if (rdata_of(32) !== 16'hA5C3) begin
      mismatched++;
      $display("FAIL read_data: got %h want a5c3", rdata_of(32));
    end
    compared++;
    if (mdt_log[65] !== 1'b0) begin
      mismatched++;
      $display("FAIL read_release: mdt got %b want 0", mdt_log[65]);
    end
  endtask

  task automatic test_mismatch();
    rd_val = 16'h1234;
    snap();
    run_frame(32, 2'b01, 2'b01, 5'b00001, 5'b10001, 2'b10, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, 5'b00001, 5'b10001, 2'b11, 16'h0, -1);
    compared++;
    if (n_wr - s_wr !== 0 || n_rd - s_rd !== 0 || n_err - s_err !== 0 || n_mdt - s_mdt !== 0) begin
      mismatched++;
      $display("FAIL mismatch_quiet: wr/rd/err/mdt got %0d/%0d/%0d/%0d want 0/0/0/0",
               n_wr - s_wr, n_rd - s_rd, n_err - s_err, n_mdt - s_mdt);
    end
    compared++;
    if (rdata_of(32) !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL mismatch_rdata: got %h want ffff", rdata_of(32));
    end
  endtask

  task automatic test_preamble();
    rd_val = 16'h3C96;
    snap();
    run_frame(31, 2'b01, 2'b10, 5'b10001, 5'b10001, 2'b11, 16'h0, -1);
    compared++;
    if (n_rd - s_rd !== 0 || n_err - s_err !== 0 || n_mdt - s_mdt !== 0 || rdata_of(31) !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL pre31_ignored: rd/err/mdt/data got %0d/%0d/%0d/%h want 0/0/0/ffff",
               n_rd - s_rd, n_err - s_err, n_mdt - s_mdt, rdata_of(31));
    end
    snap();
    run_frame(32, 2'b01, 2'b10, 5'b10001, 5'b10001, 2'b11, 16'h0, -1);
    compared++;
    if (n_rd - s_rd !== 1 || rdata_of(32) !== 16'h3C96) begin
      mismatched++;
      $display("FAIL pre32_accepted: rd/data got %0d/%h want 1/3c96", n_rd - s_rd, rdata_of(32));
    end
  endtask

  task automatic test_errors();
    snap();
    run_frame(32, 2'b01, 2'b01, 5'b10001, 5'b00011, 2'b11, 16'h7777, -1);
    compared++;
    if (n_err - s_err !== 1 || n_wr - s_wr !== 0) begin
      mismatched++;
      $display("FAIL err_ta: err/wr got %0d/%0d want 1/0", n_err - s_err, n_wr - s_wr);
    end
    snap();
    run_frame(32, 2'b01, 2'b11, 5'b10001, 5'b00011, 2'b10, 16'h7777, -1);
    compared++;
    if (n_err - s_err !== 1 || n_wr - s_wr !== 0) begin
      mismatched++;
      $display("FAIL err_op: err/wr got %0d/%0d want 1/0", n_err - s_err, n_wr - s_wr);
    end
    snap();
    run_frame(32, 2'b01, 2'b01, 5'b10001, 5'b00011, 2'b10, 16'h0F0F, -1);
    compared++;
    if (n_wr - s_wr !== 1 || last_wr_data !== 16'h0F0F || last_wr_addr !== 5'd3 || n_err - s_err !== 0) begin
      mismatched++;
      $display("FAIL err_recover: wr/data/addr/err got %0d/%h/%0d/%0d want 1/0f0f/3/0",
               n_wr - s_wr, last_wr_data, last_wr_addr, n_err - s_err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int          pre_n, kind, sel;
      logic [1:0]  st, op, ta;
      logic [4:0]  phy, rg;
      logic [15:0] wd, exp_rd;
      pre_n = $urandom_range(30, 34);
      st = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b01;
      sel = $urandom_range(0, 5);
      op = (sel < 2) ? 2'b10 : (sel < 4) ? 2'b01 : (sel == 4) ? 2'b11 : 2'b00;
      phy = $urandom_range(0, 1) ? 5'd17 : 5'($urandom_range(0, 31));
      rg = 5'($urandom_range(0, 31));
      ta = $urandom_range(0, 2) != 0 ? 2'b10 : 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      rd_val = 16'($urandom);
      kind = model_kind(pre_n, st, op, phy, ta);
      snap();
      run_frame(pre_n, st, op, phy, rg, ta, wd, -1);
      compared++;
      if (n_wr - s_wr !== int'(kind == K_WR) || n_rd - s_rd !== int'(kind == K_RD) ||
          n_err - s_err !== int'(kind == K_ERR)) begin
        mismatched++;
        $display("FAIL rand%0d_pulses: wr/rd/err got %0d/%0d/%0d want kind %0d",
                 it, n_wr - s_wr, n_rd - s_rd, n_err - s_err, kind);
      end
      compared++;
      if ((n_mdt - s_mdt > 0) !== (kind == K_RD)) begin
        mismatched++;
        $display("FAIL rand%0d_mdt: got %0d drive cycles want active=%0d", it, n_mdt - s_mdt, kind == K_RD);
      end
      if (kind == K_WR) begin
        compared++;
        if (last_wr_addr !== rg || last_wr_data !== wd) begin
          mismatched++;
          $display("FAIL rand%0d_wr: got %0d/%h want %0d/%h", it, last_wr_addr, last_wr_data, rg, wd);
        end
      end
      if (op == 2'b10) begin
        exp_rd = (kind == K_RD) ? rd_val : 16'hFFFF;
        compared++;
        if (rdata_of(pre_n) !== exp_rd || (kind == K_RD && last_rd_addr !== rg)) begin
          mismatched++;
          $display("FAIL rand%0d_rd: data/addr got %h/%0d want %h/%0d",
                   it, rdata_of(pre_n), last_rd_addr, exp_rd, rg);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    rd_val = 16'hFFFF;
    run_frame(32, 2'b01, 2'b10, 5'b10001, 5'b01010, 2'b11, 16'h0, 7);
    compared++;
    if ({mdt, mdo, reg_addr} !== 7'b0) begin
      mismatched++;
      $display("FAIL abort_after: mdt/mdo/addr got %b/%b/%0d want 0/0/0", mdt, mdo, reg_addr);
    end
    rd_val = 16'h5A5A;
    snap();
    run_frame(32, 2'b01, 2'b10, 5'b10001, 5'b01010, 2'b11, 16'h0, -1);
    compared++;
    if (rdata_of(32) !== 16'h5A5A || n_rd - s_rd !== 1) begin
      mismatched++;
      $display("FAIL abort_reread: data/rd got %h/%0d want 5a5a/1", rdata_of(32), n_rd - s_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_preamble();
    test_errors();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
